// File: rtl/mem_line_responder.sv
// Line-granular backing-store responder for the cache fill/writeback path.
// Define MEM_LINE_RESPONDER_CRITICAL_WORD_FIRST_EN to start read bursts at the requested word.
module mem_line_responder #(
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LINE_SIZE_BYTES = 64,
    parameter int MEM_LINES       = 1024,
    parameter int READ_LATENCY    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_write_i,
    input  logic [ADDRESS_WIDTH-1:0] req_addr_i,
    input  logic                     wdata_valid_i,
    output logic                     wdata_ready_o,
    input  logic [DATA_WIDTH-1:0]    wdata_i,
    output logic                     rdata_valid_o,
    input  logic                     rdata_ready_i,
    output logic [DATA_WIDTH-1:0]    rdata_o,
    output logic                     rdata_last_o,
    output logic                     wr_done_o,
    output logic                     busy_o
);

    localparam int BEATS       = LINE_SIZE_BYTES * 8 / DATA_WIDTH;
    localparam int BEAT_BITS   = $clog2(BEATS);
    localparam int OFFSET_BITS = $clog2(LINE_SIZE_BYTES);
    localparam int WORD_BITS   = $clog2(DATA_WIDTH / 8);
    localparam int LINE_BITS   = $clog2(MEM_LINES);
    localparam int LAT_BITS    = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    localparam logic [LAT_BITS-1:0]  LAT_INIT  = LAT_BITS'(READ_LATENCY);
    localparam logic [LAT_BITS-1:0]  LAT_ONE   = LAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] BEAT_ONE  = BEAT_BITS'(1);
    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_RBURST = 3'd2,
        ST_WBURST = 3'd3,
        ST_WRESP  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [LINE_BITS-1:0]   line_q, line_d;
    logic [BEAT_BITS-1:0]   beat_q, beat_d;
    logic [BEAT_BITS-1:0]   rcnt_q, rcnt_d;
    logic [LAT_BITS-1:0]    lat_q, lat_d;
    logic                   req_ready_q, req_ready_d;
    logic                   wdata_ready_q, wdata_ready_d;
    logic                   rdata_valid_q, rdata_valid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rdata_last_q, rdata_last_d;
    logic                   wr_done_q, wr_done_d;
    logic                   busy_q, busy_d;

    logic [DATA_WIDTH-1:0]  mem_q [0:MEM_LINES*BEATS-1];

    logic [LINE_BITS-1:0]   req_line_s;
    logic [BEAT_BITS-1:0]   start_beat_s;
    logic [LINE_BITS-1:0]   rd_line_s;
    logic [BEAT_BITS-1:0]   rd_beat_s;
    logic                   load_s;
    logic                   mem_we_s;
    logic                   unused_addr_s;

    assign req_line_s    = req_addr_i[OFFSET_BITS +: LINE_BITS];
    assign unused_addr_s = ^req_addr_i;

`ifdef MEM_LINE_RESPONDER_CRITICAL_WORD_FIRST_EN
    assign start_beat_s = req_addr_i[WORD_BITS +: BEAT_BITS];
`else
    assign start_beat_s = {BEAT_BITS{1'b0}};
`endif

    // Next-state and next-output logic; outputs are registered from the next state.
    always_comb begin
        state_d   = state_q;
        line_d    = line_q;
        beat_d    = beat_q;
        rcnt_d    = rcnt_q;
        lat_d     = lat_q;
        rd_line_s = line_q;
        rd_beat_s = beat_q;
        load_s    = 1'b0;
        mem_we_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && req_ready_q) begin
                    line_d = req_line_s;
                    rcnt_d = {BEAT_BITS{1'b0}};
                    if (req_write_i) begin
                        state_d = ST_WBURST;
                        beat_d  = {BEAT_BITS{1'b0}};
                    end else if (READ_LATENCY == 0) begin
                        // Zero latency: fetch the first beat straight from the request address.
                        state_d   = ST_RBURST;
                        beat_d    = start_beat_s;
                        rd_line_s = req_line_s;
                        rd_beat_s = start_beat_s;
                        load_s    = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        beat_d  = start_beat_s;
                        lat_d   = LAT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (lat_q <= LAT_ONE) begin
                    state_d = ST_RBURST;
                    load_s  = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_ONE;
                end
            end
            ST_RBURST: begin
                if (rdata_valid_q && rdata_ready_i) begin
                    if (rcnt_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_d    = beat_q + BEAT_ONE;
                        rcnt_d    = rcnt_q + BEAT_ONE;
                        rd_beat_s = beat_q + BEAT_ONE;
                        load_s    = 1'b1;
                    end
                end else begin
                    state_d = ST_RBURST;
                end
            end
            ST_WBURST: begin
                if (wdata_valid_i && wdata_ready_q) begin
                    mem_we_s = 1'b1;
                    beat_d   = beat_q + BEAT_ONE;
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_WRESP;
                    end else begin
                        state_d = ST_WBURST;
                    end
                end else begin
                    state_d = ST_WBURST;
                end
            end
            ST_WRESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d   = (state_d == ST_IDLE);
        wdata_ready_d = (state_d == ST_WBURST);
        rdata_valid_d = (state_d == ST_RBURST);
        wr_done_d     = (state_d == ST_WRESP);
        busy_d        = (state_d != ST_IDLE);

        // Read beat and its last flag only change on a fetch, so they hold through stalls.
        if (load_s) begin
            rdata_d      = mem_q[{rd_line_s, rd_beat_s}];
            rdata_last_d = (rcnt_d == LAST_BEAT);
        end else if (state_d != ST_RBURST) begin
            rdata_d      = {DATA_WIDTH{1'b0}};
            rdata_last_d = 1'b0;
        end else begin
            rdata_d      = rdata_q;
            rdata_last_d = rdata_last_q;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            line_q        <= {LINE_BITS{1'b0}};
            beat_q        <= {BEAT_BITS{1'b0}};
            rcnt_q        <= {BEAT_BITS{1'b0}};
            lat_q         <= {LAT_BITS{1'b0}};
            req_ready_q   <= 1'b0;
            wdata_ready_q <= 1'b0;
            rdata_valid_q <= 1'b0;
            rdata_q       <= {DATA_WIDTH{1'b0}};
            rdata_last_q  <= 1'b0;
            wr_done_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            line_q        <= line_d;
            beat_q        <= beat_d;
            rcnt_q        <= rcnt_d;
            lat_q         <= lat_d;
            req_ready_q   <= req_ready_d;
            wdata_ready_q <= wdata_ready_d;
            rdata_valid_q <= rdata_valid_d;
            rdata_q       <= rdata_d;
            rdata_last_q  <= rdata_last_d;
            wr_done_q     <= wr_done_d;
            busy_q        <= busy_d;
        end
    end

    // Backing store is never reset; a partially written line stays as written.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[{line_q, beat_q}] <= wdata_i;
        end
    end

    assign req_ready_o   = req_ready_q;
    assign wdata_ready_o = wdata_ready_q;
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_o       = rdata_q;
    assign rdata_last_o  = rdata_last_q;
    assign wr_done_o     = wr_done_q;
    assign busy_o        = busy_q;

endmodule
